// File: rtl/multicycle_addsub.sv
// multicycle_addsub: chunk-serial two's-complement adder/subtractor.
// The operation is computed CHUNK bits per clock through a narrow adder slice.
// Operands are accepted with a valid/ready handshake. The result and its
// carry/overflow/zero/negative flags are held until the consumer takes them.
module multicycle_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // A one-chunk configuration still gets a 1-bit counter so that all
  // declarations stay legal.
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Latched operands. b_op already holds the inverted subtrahend in subtract mode.
  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;
  // Partial sum, filled one chunk per RUN cycle.
  logic [WIDTH-1:0] sum_acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Chunk views of the operands.
  logic [CHUNK-1:0] a_chunk [NCHUNK];
  logic [CHUNK-1:0] b_chunk [NCHUNK];
  logic [CHUNK-1:0] a_sel;
  logic [CHUNK-1:0] b_sel;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] sum_full;
  logic             last_chunk;
  logic             msb_cin;
  logic             msb_cout;

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunks
    assign a_chunk[gi] = a_op[gi*CHUNK +: CHUNK];
    assign b_chunk[gi] = b_op[gi*CHUNK +: CHUNK];
  end

  // Select the chunk addressed by the counter.
  always_comb begin
    a_sel = a_chunk[0];
    b_sel = b_chunk[0];
    for (int i = 1; i < NCHUNK; i++) begin
      if (cnt == CW'(i)) begin
        a_sel = a_chunk[i];
        b_sel = b_chunk[i];
      end
    end
  end

  // The narrow adder slice: one chunk plus the carry from the previous chunk.
  always_comb begin
    chunk_sum = {1'b0, a_sel} + {1'b0, b_sel} + {{CHUNK{1'b0}}, carry};
  end

  // Partial sum with the current chunk merged in. On the last chunk this is
  // the complete result, so flags can be taken from it at the same time.
  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_merge
    assign sum_full[gi*CHUNK +: CHUNK] = (cnt == CW'(gi)) ? chunk_sum[CHUNK-1:0]
                                                          : sum_acc[gi*CHUNK +: CHUNK];
  end

  assign last_chunk = (cnt == LAST);
  assign msb_cout   = chunk_sum[CHUNK];
  // The carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ cin.
  // This works for any CHUNK, including the bit-serial case.
  assign msb_cin    = a_op[WIDTH-1] ^ b_op[WIDTH-1] ^ sum_full[WIDTH-1];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_chunk) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, process one chunk per RUN cycle,
  // and register the result and flags when entering DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_op    <= '0;
      b_op    <= '0;
      sum_acc <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      out_s   <= '0;
      out_c   <= 1'b0;
      out_v   <= 1'b0;
      out_z   <= 1'b0;
      out_n   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_op  <= in_a;
            // Subtraction is a + ~b + 1. A borrow-in cancels that +1.
            b_op  <= in_sub ? ~in_b : in_b;
            carry <= in_sub ? ~in_c : in_c;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_acc <= sum_full;
          carry   <= msb_cout;
          if (last_chunk) begin
            out_s <= sum_full;
            out_c <= msb_cout;
            out_v <= msb_cin ^ msb_cout;
            out_z <= (sum_full == '0);
            out_n <= sum_full[WIDTH-1];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/multicycle_addsub.md
Name: multicycle_addsub

Overview:
- Parametrised, chunk-serial two's-complement adder/subtractor.
- Generalises the fixed 5-bit ripple add/subtract unit to WIDTH bits, processing CHUNK bits per clock.
- Uses a valid/ready handshake on both sides and reports carry, overflow, zero and negative flags.
- Sits between an operand source (register file or test driver) and a result consumer; trades latency for a small CHUNK-bit adder slice.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- CHUNK, 4, bits processed per cycle; must divide WIDTH exactly and satisfy 1 ≤ CHUNK ≤ WIDTH.
- NCHUNK (localparam) = WIDTH/CHUNK, number of compute cycles.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  minuend/augend.
- in_b  input  WIDTH  subtrahend/addend.
- in_sub  input  1  0 = add, 1 = subtract.
- in_c  input  1  carry-in (add) / borrow-in (subtract).
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer takes the result.
- out_s  output  WIDTH  result.
- out_c  output  1  raw carry-out of MSB; in subtract mode 1 = no borrow.
- out_v  output  1  signed overflow.
- out_z  output  1  out_s == 0.
- out_n  output  1  out_s[WIDTH-1].

Behaviour:
- Reset (async, reset_n=0):
  - State = IDLE, in_ready=1.
  - out_valid=0; out_s, out_c, out_v, out_z, out_n all 0.
  - Chunk counter = 0, internal carry = 0.
  - Reset mid-RUN or mid-DONE discards the operation; no partial result is ever flagged valid.
- States: IDLE, RUN, DONE.
  - in_ready = 1 only in IDLE.
  - out_valid = 1 only in DONE.
- IDLE:
  - On in_valid & in_ready: latch A = in_a and B' = in_sub ? ~in_b : in_b.
  - Set carry = in_sub ? ~in_c : in_c and counter = 0; go to RUN.
  - Operand inputs are ignored outside the accept edge.
- RUN, each cycle with counter = k:
  - {carry, S[k*CHUNK +: CHUNK]} = A[k*CHUNK +: CHUNK] + B'[k*CHUNK +: CHUNK] + carry.
  - On the last chunk (k = NCHUNK-1): record the carry into bit WIDTH-1 and the carry out of bit WIDTH-1, then go to DONE.
  - Otherwise counter increments.
- Arithmetic:
  - add: out_s = (in_a + in_b + in_c) mod 2^WIDTH.
  - subtract: out_s = (in_a - in_b - in_c) mod 2^WIDTH.
  - out_c = carry out of bit WIDTH-1.
  - out_v = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
  - out_z and out_n are derived from the final out_s and registered on entry to DONE.
- Latency: if operands are accepted at edge t, out_valid rises after edge t+NCHUNK. Throughput is one operation per NCHUNK+1 cycles minimum, since DONE→IDLE costs one edge.
- DONE:
  - Outputs are stable while out_ready=0, held indefinitely (backpressure).
  - On out_ready=1: go to IDLE; out_valid drops the next cycle.
  - out_s and flags keep their last value after leaving DONE until the next DONE entry.
- Simultaneous events:
  - in_valid during RUN/DONE is not accepted (in_ready=0); the source must hold it.
  - out_ready=1 outside DONE has no effect.
- CHUNK = WIDTH degenerates to a single compute cycle; CHUNK = 1 is fully bit-serial.

Test Plan:
- WIDTH=16, CHUNK=4: add 0x1234+0x0FED, in_c=0 → out_s=0x2221, c=0, v=0, z=0, n=0; out_valid exactly 4 cycles after accept.
- Subtract 0x0005-0x0007, in_c=0 → out_s=0xFFFE, c=0 (borrow), v=0, n=1. Subtract 0x0007-0x0005, in_c=1 → out_s=0x0001, c=1.
- Overflow/wrap:
  - 0x7FFF+0x0001 → 0x8000, v=1, n=1.
  - 0xFFFF+0x0001 → 0x0000, c=1, v=0, z=1.
  - 0x8000-0x0001 → 0x7FFF, v=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → out_s/flags/out_valid stable and in_ready=0. A new in_valid held meanwhile is accepted only on the first IDLE cycle.
- Reset: assert reset_n=0 on the 2nd RUN cycle → all outputs 0 and in_ready=1 immediately (async). After release, a fresh 0x0001+0x0001 yields 0x0002 with correct latency.
- Parameter sweep: WIDTH=5, CHUNK=1 and WIDTH=8, CHUNK=8 → random add/subtract results match a reference model, with latency 5 and 1 respectively.
